// File: rtl/shift_pulse_gen_pkg.sv
// Shared definitions for the pushbutton-to-shift-strobe front end.
// Holds the FSM state encoding and the counter sizing helpers.
package shift_pulse_gen_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StDbPress   = 2'd1,
    StHeld      = 2'd2,
    StDbRelease = 2'd3
  } state_e;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous button and switch inputs.
// Synchronous active-high reset clears both stages.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/shift_pulse_gen.sv
// Debounces a raw pushbutton into one-cycle shift strobes and a clean level,
// with optional auto-repeat while the button stays held.
module shift_pulse_gen
  import shift_pulse_gen_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4096,
  parameter int unsigned REPEAT_DELAY  = 0,
  parameter int unsigned REPEAT_PERIOD = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse,
  output logic level
);

  localparam int unsigned DbW = cnt_width(STABLE_CYCLES);
  localparam int unsigned RpW = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam bit          RepeatEn = (REPEAT_DELAY > 0);

  localparam logic [DbW-1:0] DbLast     = DbW'(STABLE_CYCLES - 1);
  localparam logic [RpW-1:0] DelayLast  = RpW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RpW-1:0] PeriodLast = RpW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  logic s2;

  sync_2ff u_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (btn),
    .q_o   (s2)
  );

  state_e           state_q;
  logic [DbW-1:0]   db_cnt_q;
  logic [RpW-1:0]   rp_cnt_q;
  logic             rp_started_q;  // first (delay) strobe already issued
  logic             pulse_q;
  logic             level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      db_cnt_q     <= '0;
      rp_cnt_q     <= '0;
      rp_started_q <= 1'b0;
      pulse_q      <= 1'b0;
      level_q      <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (s2) begin
            state_q  <= StDbPress;
            db_cnt_q <= '0;
          end
        end
        StDbPress: begin
          if (!s2) begin
            state_q <= StIdle;
          end else if (db_cnt_q == DbLast) begin
            state_q      <= StHeld;
            pulse_q      <= 1'b1;
            level_q      <= 1'b1;
            rp_cnt_q     <= '0;
            rp_started_q <= 1'b0;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        StHeld: begin
          // A release seen here takes priority over a due repeat strobe.
          if (!s2) begin
            state_q  <= StDbRelease;
            db_cnt_q <= '0;
          end else if (RepeatEn) begin
            if (rp_cnt_q == (rp_started_q ? PeriodLast : DelayLast)) begin
              pulse_q      <= 1'b1;
              rp_cnt_q     <= '0;
              rp_started_q <= 1'b1;
            end else begin
              rp_cnt_q <= rp_cnt_q + 1'b1;
            end
          end
        end
        StDbRelease: begin
          // Repeat counter is left untouched so the schedule resumes on bounce-back.
          if (s2) begin
            state_q <= StHeld;
          end else if (db_cnt_q == DbLast) begin
            state_q <= StIdle;
            level_q <= 1'b0;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pulse = pulse_q;
  assign level = level_q;

endmodule

// File: tb/tb_shift_pulse_gen.sv
// Directed bench: one instance without auto-repeat, one with delay 8 / period 4,
// both debouncing over 4 cycles and sharing the same button and reset.
module tb_shift_pulse_gen;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic p0, l0, p1, l1;

  int unsigned vectors = 0;
  int unsigned errs    = 0;

  always #5 clk = ~clk;

  shift_pulse_gen #(
    .STABLE_CYCLES (4),
    .REPEAT_DELAY  (0),
    .REPEAT_PERIOD (4)
  ) u_norep (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .pulse (p0),
    .level (l0)
  );

  shift_pulse_gen #(
    .STABLE_CYCLES (4),
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4)
  ) u_rep (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .pulse (p1),
    .level (l1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
    end
  endtask

  // Button low from the next edge: level drops 7 edges later, no strobes.
  task automatic release_check(input string tag);
    btn = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk({tag, "_rel_p0"}, i, p0, 1'b0);
      chk({tag, "_rel_l0"}, i, l0, i < 7);
      chk({tag, "_rel_p1"}, i, p1, 1'b0);
      chk({tag, "_rel_l1"}, i, l1, i < 7);
    end
  endtask

  // Clean 20-cycle hold; the repeating instance strobes at 7, 15, 19 and its
  // strobe due at 23 collides with the release and must be dropped.
  task automatic clean_press(input string tag);
    btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk({tag, "_p0"}, i, p0, i == 7);
      chk({tag, "_l0"}, i, l0, i >= 7);
      chk({tag, "_p1"}, i, p1, (i == 7) || (i == 15) || (i == 19));
      chk({tag, "_l1"}, i, l1, i >= 7);
    end
    release_check(tag);
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("rst_p0", i, p0, 1'b0);
      chk("rst_l0", i, l0, 1'b0);
      chk("rst_p1", i, p1, 1'b0);
      chk("rst_l1", i, l1, 1'b0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("post_rst_p0", i, p0, i == 7);
      chk("post_rst_l0", i, l0, i >= 7);
      chk("post_rst_p1", i, p1, i == 7);
      chk("post_rst_l1", i, l1, i >= 7);
    end
    release_check("post_rst");

    clean_press("clean");

    // Bounce 1,0,1,0 in pairs, then steady high from edge 9.
    for (int i = 1; i <= 20; i++) begin
      btn = (i <= 2) || (i == 5) || (i == 6) || (i >= 9);
      step();
      chk("bounce_p0", i, p0, i == 15);
      chk("bounce_l0", i, l0, i >= 15);
      chk("bounce_p1", i, p1, i == 15);
      chk("bounce_l1", i, l1, i >= 15);
    end
    release_check("bounce");

    btn = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      chk("rep_p0", i, p0, i == 7);
      chk("rep_p1", i, p1, (i == 7) || ((i >= 15) && (((i - 15) % 4) == 0)));
      chk("rep_l1", i, l1, i >= 7);
    end
    release_check("rep");

    // Two-cycle dropout while held: 3 frozen edges push the first repeat to 18.
    for (int i = 1; i <= 30; i++) begin
      btn = !((i == 10) || (i == 11));
      step();
      chk("hbounce_p0", i, p0, i == 7);
      chk("hbounce_l0", i, l0, i >= 7);
      chk("hbounce_p1", i, p1, (i == 7) || (i == 18) || (i == 22) || (i == 26) || (i == 30));
      chk("hbounce_l1", i, l1, i >= 7);
    end
    release_check("hbounce");

    // Reset lands while the debounce counter holds 2.
    btn = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("midrst_pre_p0", i, p0, 1'b0);
    end
    rst = 1'b1;
    step();
    chk("midrst_p0", 0, p0, 1'b0);
    chk("midrst_l0", 0, l0, 1'b0);
    chk("midrst_p1", 0, p1, 1'b0);
    rst = 1'b0;
    btn = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("midrst_post_p0", i, p0, 1'b0);
      chk("midrst_post_l0", i, l0, 1'b0);
      chk("midrst_post_p1", i, p1, 1'b0);
    end
    clean_press("again");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
